// File: rtl/cmos_pkg.sv
// Shared camera geometry and capture FSM state encoding.
// Used by both the timing source and the capture side.
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE
  } cap_state_t;

  localparam int unsigned DEF_H_ACTIVE  = 800;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_HDR_BYTES = 54;
  localparam int unsigned DEF_BPP_BYTES = 3;

endpackage

// File: rtl/cmos_sync_edge.sv
// Registers vsync/href once and derives edge pulses
// from the registered copy versus the current sample.
module cmos_sync_edge #(
  parameter logic VS_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmos_vsync,
  input  logic cmos_href,
  output logic sync_act,
  output logic sync_on,
  output logic sync_off,
  output logic href_rise,
  output logic href_fall
);

  logic sync_q;
  logic href_q;

  assign sync_act  = (cmos_vsync == VS_POL);
  assign sync_on   = sync_act & ~sync_q;
  assign sync_off  = ~sync_act & sync_q;
  assign href_rise = cmos_href & ~href_q;
  assign href_fall = ~cmos_href & href_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      href_q <= 1'b0;
    end else begin
      sync_q <= sync_act;
      href_q <= cmos_href;
    end
  end

endmodule

// File: rtl/cmos_capture.sv
// Camera capture: tracks frame position and emits one
// write per active pixel into a bottom-up BMP buffer.
module cmos_capture
  import cmos_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter logic        VS_POL    = 1'b0,
  parameter int unsigned HDR_BYTES = DEF_HDR_BYTES,
  parameter int unsigned BPP_BYTES = DEF_BPP_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [23:0] cmos_data,
  output logic        wr_en,
  output logic [31:0] wr_index,
  output logic [23:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [11:0] line_cnt
);

  localparam logic [31:0] LINE_B =
    32'(H_ACTIVE * BPP_BYTES);
  localparam logic [31:0] BASE0 =
    32'(HDR_BYTES + (V_ACTIVE - 1) * H_ACTIVE * BPP_BYTES);
  localparam logic [31:0] BPP_B = 32'(BPP_BYTES);
  localparam logic [11:0] LAST_LINE = 12'(V_ACTIVE - 1);

  cap_state_t state, state_nx;

  logic        sync_act, sync_on, sync_off;
  logic        href_rise, href_fall;
  logic [31:0] row_base;
  logic [31:0] x_off;
  logic [31:0] x_eff;
  logic        do_start, do_abort, do_pix;
  logic        do_drop, do_line, do_done;

  cmos_sync_edge #(
    .VS_POL(VS_POL)
  ) u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmos_vsync(cmos_vsync),
    .cmos_href (cmos_href),
    .sync_act  (sync_act),
    .sync_on   (sync_on),
    .sync_off  (sync_off),
    .href_rise (href_rise),
    .href_fall (href_fall)
  );

  assign x_eff = href_rise ? 32'd0 : x_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_start = 1'b0;
    do_abort = 1'b0;
    do_pix   = 1'b0;
    do_drop  = 1'b0;
    do_line  = 1'b0;
    do_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_act) state_nx = SYNC;
      end
      SYNC: begin
        if (sync_off) begin
          do_start = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        // sync arriving mid-frame outranks any pixel or line event
        if (sync_on) begin
          do_abort = 1'b1;
          state_nx = SYNC;
        end else begin
          if (cmos_href) begin
            if (x_eff < LINE_B) do_pix  = 1'b1;
            else                do_drop = 1'b1;
          end
          if (href_fall) begin
            do_line = 1'b1;
            if (line_cnt == LAST_LINE) begin
              do_done  = 1'b1;
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_index    <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      line_cnt    <= '0;
      row_base    <= '0;
      x_off       <= '0;
    end else begin
      wr_en       <= do_pix;
      frame_start <= do_start;
      frame_done  <= do_done | do_abort;
      if (do_pix) begin
        wr_data  <= cmos_data;
        wr_index <= row_base + x_eff;
      end
      if (do_start)   x_off <= '0;
      else if (do_pix) x_off <= x_eff + BPP_B;
      else if (href_rise) x_off <= '0;
      if (do_start) begin
        row_base <= BASE0;
        line_cnt <= '0;
      end else if (do_line) begin
        row_base <= row_base - LINE_B;
        line_cnt <= line_cnt + 12'd1;
      end
      if (do_start)
        frame_err <= 1'b0;
      else if (do_abort || do_drop ||
               (do_line && x_off != LINE_B))
        frame_err <= 1'b1;
    end
  end

endmodule
